hsi_frame_ctrl: RTL
===================

// Module: hsi_frame_ctrl
// PURPOSE
//  Frame sequencer for the RGB->HSI converter. Takes RGB888 pixels from an upstream valid/ready
//  stream and drives the converter inputs (RGB_hsync/RGB_vsync/RGB_data/RGB_de) with H_DISP x V_DISP
//  raster timing plus blanking. Counts the converter's HSI_de pulses and flags the frame complete.
//  Supports single-shot and continuous frames, a graceful stop, and upstream stall accounting.
// PARAMETERS
//  H_DISP   640  active pixels per line
//  V_DISP   480  active lines per frame
//  H_BLANK  160  blanking cycles per line (>= HS_W, >= 1)
//  V_BLANK  45   blanking lines per frame (>= VS_W, >= 1)
//  HS_W     96   hsync width in cycles; starts at h_cnt = H_DISP
//  VS_W     2    vsync width in lines; starts at v_cnt = V_DISP
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous reset, active-high
//  start      in   1   one-cycle pulse; begins a frame from IDLE
//  cont_mode  in   1   1 = run frames back-to-back; sampled at the end of each VBLANK
//  stop       in   1   pulse; current frame completes, then return to IDLE
//  pix_valid  in   1   upstream pixel valid
//  pix_data   in   24  upstream pixel {R[23:16],G[15:8],B[7:0]}
//  pix_ready  out  1   = (state == ACTIVE); combinational
//  RGB_hsync  out  1   converter hsync, active-high, registered
//  RGB_vsync  out  1   converter vsync, active-high, registered
//  RGB_data   out  24  converter pixel, registered
//  RGB_de     out  1   converter data enable, registered
//  HSI_de     in   1   converter output enable, used to count output pixels
//  busy       out  1   state != IDLE
//  frame_done out  1   one-cycle pulse when H_DISP*V_DISP HSI_de pulses are counted
//  stall_cnt  out  16  ACTIVE cycles with pix_valid = 0, saturating; cleared on start from IDLE
// BEHAVIOUR
//  - Reset: state = IDLE; h_cnt, v_cnt, out_cnt and stall_cnt = 0; stop_pend = 0.
//    All outputs are 0, including RGB_data. Reset overrides everything, including a running frame.
//  - States: IDLE, ACTIVE, HBLANK, VBLANK.
//    IDLE   -> ACTIVE on start. h_cnt = v_cnt = 0, out_cnt = 0, stall_cnt = 0.
//    ACTIVE : accept = pix_valid & pix_ready. h_cnt increments only on accept.
//             When the accept with h_cnt = H_DISP-1 occurs: go to HBLANK and set h_cnt = H_DISP.
//    HBLANK : h_cnt counts every cycle up to H_DISP+H_BLANK-1, then sets h_cnt = 0 and v_cnt += 1.
//             If the new v_cnt < V_DISP -> ACTIVE; otherwise -> VBLANK.
//    VBLANK : h_cnt free-runs over 0..H_DISP+H_BLANK-1 and v_cnt increments at each wrap.
//             At the wrap of line V_DISP+V_BLANK-1: v_cnt = 0, h_cnt = 0.
//             If cont_mode = 1 and stop_pend = 0 -> ACTIVE (out_cnt kept, stall_cnt kept).
//             Otherwise -> IDLE and stop_pend is cleared.
//  - start while busy is ignored. stop in IDLE is ignored. stop while busy sets stop_pend.
//  - Datapath latency is 1 clk. After each edge, RGB_de = accept and RGB_data = pix_data.
//    RGB_data is updated only on accept and holds its value otherwise.
//  - Stalls: while ACTIVE with pix_valid = 0, RGB_de = 0, the counters freeze and stall_cnt
//    increments, saturating at 16'hFFFF. The converter treats de = 0 as a bubble.
//  - Sync outputs are registered from the current state and counters:
//    RGB_hsync = 1 when h_cnt is in [H_DISP, H_DISP+HS_W) in HBLANK or VBLANK.
//    RGB_vsync = 1 when state = VBLANK and v_cnt is in [V_DISP, V_DISP+VS_W).
//  - Output count: out_cnt is $clog2(H_DISP*V_DISP+1) bits and increments on HSI_de = 1 while busy.
//    When it reaches H_DISP*V_DISP: frame_done pulses for one cycle and out_cnt returns to 0 on
//    the same edge. The converter's 3-clk latency means frame_done follows the last accept by
//    about 4 clk, inside HBLANK/VBLANK. HSI_de in IDLE is ignored.
//  - Reset mid-frame drops the frame: no frame_done, and outputs go to 0 the next cycle.
// TESTING  (small parameters: H_DISP=4 V_DISP=2 H_BLANK=3 V_BLANK=2 HS_W=1 VS_W=1,
//           converter model = 3-clk delay of RGB_de)
//  1 Reset, then start with pix_valid held 1 and data 0x000001..0x000008:
//    -> RGB_de high 4 clk per line, 2 lines; RGB_hsync 1 clk at h_cnt = 4; RGB_vsync high 7 clk;
//       frame_done once; busy falls after 2 VBLANK lines; stall_cnt = 0.
//  2 As 1, but drop pix_valid for 3 clk in the middle of line 0
//    -> RGB_de low for 3 clk; pixel order intact; stall_cnt = 3; frame_done still once.
//  3 cont_mode = 1, then 3 frames, with stop pulsed during frame 3
//    -> 3 frame_done pulses, no gap between VBLANK and ACTIVE, IDLE after frame 3.
//  4 start pulsed during ACTIVE, and stop pulsed in IDLE
//    -> both ignored; no extra frame; state unchanged.
//  5 rst asserted mid-line 1 -> outputs 0 and busy 0 the next clk; no frame_done;
//    a new start runs a clean frame as in scenario 1.
//  6 stall_cnt saturation: hold pix_valid = 0 in ACTIVE for 70000 clk -> stall_cnt = 16'hFFFF.

Source files
------------

// File: rtl/hsi_frame_ctrl.sv
// rtl/hsi_frame_ctrl.sv - raster frame sequencer feeding the RGB->HSI converter
// Paces upstream pixels into H_DISP x V_DISP timing with blanking and counts converter output.
module hsi_frame_ctrl #(
    parameter int H_DISP  = 640,
    parameter int V_DISP  = 480,
    parameter int H_BLANK = 160,
    parameter int V_BLANK = 45,
    parameter int HS_W    = 96,
    parameter int VS_W    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cont_mode,
    input  logic        stop,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic        RGB_hsync,
    output logic        RGB_vsync,
    output logic [23:0] RGB_data,
    output logic        RGB_de,
    input  logic        HSI_de,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] stall_cnt
);
    localparam int H_TOT = H_DISP + H_BLANK;
    localparam int V_TOT = V_DISP + V_BLANK;
    localparam int PIX   = H_DISP * V_DISP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int OW    = $clog2(PIX + 1);

    localparam logic [HW-1:0] H_LAST_ACT = HW'(H_DISP - 1);
    localparam logic [HW-1:0] H_BLK_BEG  = HW'(H_DISP);
    localparam logic [HW-1:0] H_END      = HW'(H_TOT - 1);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_DISP + HS_W - 1);
    localparam logic [VW-1:0] V_LAST_ACT = VW'(V_DISP - 1);
    localparam logic [VW-1:0] V_BLK_BEG  = VW'(V_DISP);
    localparam logic [VW-1:0] V_END      = VW'(V_TOT - 1);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_DISP + VS_W - 1);
    localparam logic [OW-1:0] OUT_LAST   = OW'(PIX - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t        state, state_n;
    logic [HW-1:0] h_cnt, h_n;
    logic [VW-1:0] v_cnt, v_n;
    logic [OW-1:0] out_cnt;
    logic          stop_pend, stop_pend_n;
    logic          accept;
    logic          launch;

    assign pix_ready = (state == ACTIVE);
    assign busy      = (state != IDLE);
    assign accept    = pix_valid & pix_ready;
    assign launch    = (state == IDLE) & start;

    always_comb begin
        state_n     = state;
        h_n         = h_cnt;
        v_n         = v_cnt;
        stop_pend_n = stop_pend | (stop & busy);
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = ACTIVE;
                    h_n     = '0;
                    v_n     = '0;
                end
            end
            ACTIVE: begin
                if (accept) begin
                    if (h_cnt == H_LAST_ACT) begin
                        h_n     = H_BLK_BEG;
                        state_n = HBLANK;
                    end else begin
                        h_n = h_cnt + 1'b1;
                    end
                end
            end
            HBLANK: begin
                if (h_cnt == H_END) begin
                    h_n     = '0;
                    v_n     = v_cnt + 1'b1;
                    state_n = (v_cnt == V_LAST_ACT) ? VBLANK : ACTIVE;
                end else begin
                    h_n = h_cnt + 1'b1;
                end
            end
            VBLANK: begin
                if (h_cnt == H_END) begin
                    h_n = '0;
                    if (v_cnt == V_END) begin
                        v_n = '0;
                        // A pending stop only matters once the whole frame has drained
                        if (cont_mode && !stop_pend) begin
                            state_n = ACTIVE;
                        end else begin
                            state_n     = IDLE;
                            stop_pend_n = 1'b0;
                        end
                    end else begin
                        v_n = v_cnt + 1'b1;
                    end
                end else begin
                    h_n = h_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            h_cnt      <= '0;
            v_cnt      <= '0;
            stop_pend  <= 1'b0;
            out_cnt    <= '0;
            stall_cnt  <= '0;
            frame_done <= 1'b0;
            RGB_de     <= 1'b0;
            RGB_data   <= '0;
            RGB_hsync  <= 1'b0;
            RGB_vsync  <= 1'b0;
        end else begin
            state      <= state_n;
            h_cnt      <= h_n;
            v_cnt      <= v_n;
            stop_pend  <= stop_pend_n;
            frame_done <= 1'b0;
            RGB_de     <= accept;
            if (accept) begin
                RGB_data <= pix_data;
            end
            RGB_hsync <= ((state == HBLANK) || (state == VBLANK)) &&
                         (h_cnt >= H_BLK_BEG) && (h_cnt <= HS_LAST);
            RGB_vsync <= (state == VBLANK) && (v_cnt >= V_BLK_BEG) && (v_cnt <= VS_LAST);

            if (launch) begin
                out_cnt <= '0;
            end else if (busy && HSI_de) begin
                if (out_cnt == OUT_LAST) begin
                    out_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end

            if (launch) begin
                stall_cnt <= '0;
            end else if ((state == ACTIVE) && !pix_valid && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
endmodule
